// File: rtl/matriz_scan_ctrl.sv
// Row-multiplexed scan controller for the 7x5 irrigation status matrix.
// Ports: clk, rst_n | nivel, irrig_on, irrig_mode, blank -> row_sel, lin, col, img_idx, frame_start
module matriz_scan_ctrl #(
  parameter int ROW_DIV    = 5000,
  parameter int DEAD       = 2,
  parameter int ALT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] nivel,
  input  logic       irrig_on,
  input  logic       irrig_mode,
  input  logic       blank,
  output logic [2:0] row_sel,
  output logic [6:0] lin,
  output logic [4:0] col,
  output logic [2:0] img_idx,
  output logic       frame_start
);

  localparam int PW = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
  localparam int AW = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(ROW_DIV - 1);
  localparam logic [PW-1:0] DEAD_P     = PW'(DEAD);
  localparam logic [AW-1:0] ALT_LAST   = AW'(ALT_FRAMES - 1);

  typedef enum logic [1:0] {
    SHOW_LEVEL,
    SHOW_IRRIG,
    SHOW_ALT_LVL
  } state_t;

  logic [PW-1:0] presc;
  logic [2:0]    row;
  logic [2:0]    img_q, img_d;
  state_t        state_q, state_d;
  logic [AW-1:0] alt_q, alt_d;

  logic       row_end;
  logic       frame_end;
  logic       dark;
  logic [2:0] lvl_img;
  logic [2:0] irr_img;

  assign row_end   = (presc == PRESC_LAST);
  assign frame_end = row_end && (row == 3'd6);
  assign lvl_img   = {1'b0, nivel};
  assign irr_img   = {2'b10, irrig_mode};

  // Level images light the bottom rows fully; fuller tank = more rows.
  function automatic logic [4:0] rom(input logic [2:0] img,
                                     input logic [2:0] r);
    logic [4:0] v;
    v = 5'b00000;
    case (img)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        v = (r >= (3'd6 - {img[1:0], 1'b0})) ? 5'b11111 : 5'b10001;
      end
      3'd4: begin
        case (r)
          3'd1:    v = 5'b00100;
          3'd2:    v = 5'b10101;
          3'd3:    v = 5'b01010;
          3'd4:    v = 5'b00100;
          3'd5:    v = 5'b00100;
          3'd6:    v = 5'b11111;
          default: v = 5'b00000;
        endcase
      end
      3'd5: begin
        case (r)
          3'd1:    v = 5'b00100;
          3'd2:    v = 5'b00100;
          3'd3:    v = 5'b01110;
          3'd4:    v = 5'b11111;
          3'd5:    v = 5'b01110;
          3'd6:    v = 5'b00100;
          default: v = 5'b00000;
        endcase
      end
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      row     <= 3'd0;
      img_q   <= 3'd0;
      state_q <= SHOW_LEVEL;
      alt_q   <= '0;
    end else begin
      presc <= row_end ? '0 : presc + 1'b1;
      if (row_end) begin
        row <= (row == 3'd6) ? 3'd0 : row + 3'd1;
      end
      // Image only changes between frames so a frame is never torn.
      if (frame_end) begin
        state_q <= state_d;
        img_q   <= img_d;
        alt_q   <= alt_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    alt_d   = alt_q;
    case (state_q)
      SHOW_LEVEL: begin
        alt_d = '0;
        if (irrig_on) begin
          state_d = SHOW_IRRIG;
          img_d   = irr_img;
        end else begin
          img_d = lvl_img;
        end
      end
      SHOW_IRRIG: begin
        if (!irrig_on) begin
          state_d = SHOW_LEVEL;
          img_d   = lvl_img;
          alt_d   = '0;
        end else if (alt_q == ALT_LAST) begin
          state_d = SHOW_ALT_LVL;
          img_d   = lvl_img;
          alt_d   = '0;
        end else begin
          img_d = irr_img;
          alt_d = alt_q + 1'b1;
        end
      end
      SHOW_ALT_LVL: begin
        if (!irrig_on) begin
          state_d = SHOW_LEVEL;
          img_d   = lvl_img;
          alt_d   = '0;
        end else if (alt_q == ALT_LAST) begin
          state_d = SHOW_IRRIG;
          img_d   = irr_img;
          alt_d   = '0;
        end else begin
          img_d = lvl_img;
          alt_d = alt_q + 1'b1;
        end
      end
      default: begin
        state_d = SHOW_LEVEL;
        img_d   = lvl_img;
        alt_d   = '0;
      end
    endcase
  end

  // Blank the first DEAD cycles of every row so the demux settles.
  assign dark = blank || (presc < DEAD_P);

  always_comb begin
    lin = 7'h7F;
    col = 5'b00000;
    unique case (1'b1)
      dark: begin
        lin = 7'h7F;
        col = 5'b00000;
      end
      default: begin
        lin = ~(7'd1 << row);
        col = rom(img_q, row);
      end
    endcase
  end

  assign row_sel     = row;
  assign img_idx     = img_q;
  assign frame_start = frame_end;

endmodule

// File: tb/tb_matriz_scan_ctrl.sv
// Scoreboard bench for matriz_scan_ctrl (ROW_DIV=4, DEAD=1, ALT_FRAMES=2).
// Stimulus queues cycle-stamped expectations; a monitor compares at negedge.
module tb_matriz_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] nivel = 2'd3;
  logic       irrig_on = 1'b0;
  logic       irrig_mode = 1'b0;
  logic       blank = 1'b0;
  logic [2:0] row_sel;
  logic [6:0] lin;
  logic [4:0] col;
  logic [2:0] img_idx;
  logic       frame_start;

  matriz_scan_ctrl #(
    .ROW_DIV(4),
    .DEAD(1),
    .ALT_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .nivel(nivel),
    .irrig_on(irrig_on),
    .irrig_mode(irrig_mode),
    .blank(blank),
    .row_sel(row_sel),
    .lin(lin),
    .col(col),
    .img_idx(img_idx),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          in_rst;
    int          cyc;
    logic [18:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic push(input bit r, input int c, input logic [2:0] rs,
                      input logic [6:0] l, input logic [4:0] cl,
                      input logic [2:0] im, input logic fs);
    exp_t e;
    e.in_rst = r;
    e.cyc    = c;
    e.v      = {rs, l, cl, im, fs};
    q.push_back(e);
  endtask

  task automatic cmp(input exp_t e);
    logic [18:0] act;
    act = {row_sel, lin, col, img_idx, frame_start};
    checks++;
    if (act === e.v) passed++;
    else $display("FAIL cyc%0d rst=%0b row/lin/col/img/fs got %h/%h/%h/%0d/%0b want %h/%h/%h/%0d/%0b",
                  e.cyc, e.in_rst, act[18:16], act[15:9], act[8:4], act[3:1], act[0],
                  e.v[18:16], e.v[15:9], e.v[8:4], e.v[3:1], e.v[0]);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (!rst_n) begin
        if (q[0].in_rst) cmp(q.pop_front());
      end else begin
        while (q.size() > 0 && !q[0].in_rst && q[0].cyc < cyc) begin
          checks++;
          $display("FAIL missed cyc%0d (now %0d)", q[0].cyc, cyc);
          void'(q.pop_front());
        end
        if (q.size() > 0 && !q[0].in_rst && q[0].cyc == cyc)
          cmp(q.pop_front());
      end
    end
  end

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    push(1, 0, 3'd0, 7'h7F, 5'h00, 3'd0, 1'b0);
    push(0, 0, 3'd0, 7'h7F, 5'h00, 3'd0, 1'b0);
    push(0, 1, 3'd0, 7'h7E, 5'h11, 3'd0, 1'b0);
    push(0, 27, 3'd6, 7'h3F, 5'h1F, 3'd0, 1'b1);
    push(0, 28, 3'd0, 7'h7F, 5'h00, 3'd3, 1'b0);
    push(0, 29, 3'd0, 7'h7E, 5'h1F, 3'd3, 1'b0);
    push(0, 32, 3'd1, 7'h7F, 5'h00, 3'd3, 1'b0);
    push(0, 33, 3'd1, 7'h7D, 5'h1F, 3'd3, 1'b0);
    push(0, 41, 3'd3, 7'h77, 5'h1F, 3'd3, 1'b0);
    push(0, 54, 3'd6, 7'h3F, 5'h1F, 3'd3, 1'b0);
    push(0, 55, 3'd6, 7'h3F, 5'h1F, 3'd3, 1'b1);
    push(0, 69, 3'd3, 7'h77, 5'h1F, 3'd3, 1'b0);
    push(0, 81, 3'd6, 7'h3F, 5'h1F, 3'd3, 1'b0);
    push(0, 85, 3'd0, 7'h7E, 5'h11, 3'd1, 1'b0);
    push(0, 89, 3'd1, 7'h7D, 5'h11, 3'd1, 1'b0);
    push(0, 101, 3'd4, 7'h6F, 5'h1F, 3'd1, 1'b0);
    push(0, 113, 3'd0, 7'h7E, 5'h00, 3'd5, 1'b0);
    push(0, 117, 3'd1, 7'h7D, 5'h04, 3'd5, 1'b0);
    push(0, 141, 3'd0, 7'h7E, 5'h00, 3'd5, 1'b0);
    push(0, 169, 3'd0, 7'h7E, 5'h11, 3'd2, 1'b0);
    push(0, 177, 3'd2, 7'h7B, 5'h1F, 3'd2, 1'b0);
    push(0, 197, 3'd0, 7'h7E, 5'h11, 3'd2, 1'b0);
    push(0, 225, 3'd0, 7'h7E, 5'h00, 3'd5, 1'b0);
    push(0, 229, 3'd1, 7'h7D, 5'h04, 3'd5, 1'b0);
    push(0, 253, 3'd0, 7'h7E, 5'h11, 3'd2, 1'b0);
    push(0, 261, 3'd2, 7'h7B, 5'h1F, 3'd2, 1'b0);
    push(0, 262, 3'd2, 7'h7F, 5'h00, 3'd2, 1'b0);
    push(0, 263, 3'd2, 7'h7F, 5'h00, 3'd2, 1'b0);
    push(0, 264, 3'd3, 7'h7F, 5'h00, 3'd2, 1'b0);
    push(0, 265, 3'd3, 7'h77, 5'h1F, 3'd2, 1'b0);
    push(0, 297, 3'd4, 7'h6F, 5'h1F, 3'd5, 1'b0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    at(68);
    nivel = 2'd1;
    at(100);
    irrig_on   = 1'b1;
    irrig_mode = 1'b1;
    nivel      = 2'd2;
    at(230);
    irrig_on = 1'b0;
    at(262);
    blank = 1'b1;
    at(265);
    blank = 1'b0;
    at(270);
    irrig_on = 1'b1;
    at(298);
    push(1, 0, 3'd0, 7'h7F, 5'h00, 3'd0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(0, 0, 3'd0, 7'h7F, 5'h00, 3'd0, 1'b0);
    push(0, 1, 3'd0, 7'h7E, 5'h11, 3'd0, 1'b0);
    push(0, 21, 3'd5, 7'h5F, 5'h11, 3'd0, 1'b0);
    push(0, 27, 3'd6, 7'h3F, 5'h1F, 3'd0, 1'b1);
    push(0, 29, 3'd0, 7'h7E, 5'h00, 3'd5, 1'b0);
    push(0, 37, 3'd2, 7'h7B, 5'h04, 3'd5, 1'b0);
    push(0, 65, 3'd2, 7'h7B, 5'h15, 3'd4, 1'b0);
    push(0, 85, 3'd0, 7'h7E, 5'h11, 3'd2, 1'b0);
    rst_n = 1'b1;
    at(30);
    irrig_mode = 1'b0;
    at(90);
    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      checks++;
      $display("FAIL pending cyc%0d never checked", q[0].cyc);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
